// File: rtl/ref_bank_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ref_bank_writer
// Function : round-robin write sequencer filling NUM_BANK reference-pixel SRAM
//            banks in SEG_LEN-word segments, wrapping after DEPTH/SEG_LEN passes
// Revision : 1.0 - initial release
// ============================================================================
module ref_bank_writer #(
   parameter int NUM_BANK = 4,
   parameter int SEG_LEN  = 24,
   parameter int DEPTH    = 96,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 64,
   localparam int PASSES  = DEPTH / SEG_LEN,
   localparam int BANK_W  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
   localparam int PASS_W  = (PASSES > 1) ? $clog2(PASSES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              hold_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic [NUM_BANK-1:0] bank_sel_n_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              seg_done_o,
   output logic [BANK_W-1:0] seg_bank_o,
   output logic [PASS_W-1:0] seg_pass_o,
   output logic              fill_done_o,
   output logic              busy_o
);

   localparam int CNT_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic [BANK_W-1:0]   bank_idx_q, bank_idx_d;
   logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
   logic [ADDR_W-1:0]   addr_base_q, addr_base_d;
   logic [NUM_BANK-1:0] bank_sel_n_q, bank_sel_n_d;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic                seg_done_q;
   logic [BANK_W-1:0]   seg_bank_q;
   logic [PASS_W-1:0]   seg_pass_q;
   logic                fill_done_q;

   logic accept;
   logic seg_end;
   logic last_bank;
   logic last_pass;

   assign busy_o     = (state_q == S_FILL);
   assign in_ready_o = busy_o && !hold_i && !start_i;
   assign accept     = in_ready_o && in_valid_i;

   assign seg_end   = (word_cnt_q == CNT_W'(SEG_LEN - 1));
   assign last_bank = (bank_idx_q == BANK_W'(NUM_BANK - 1));
   assign last_pass = (pass_idx_q == PASS_W'(PASSES - 1));

   always_comb begin
      word_cnt_d   = word_cnt_q + CNT_W'(1);
      bank_idx_d   = bank_idx_q;
      pass_idx_d   = pass_idx_q;
      addr_base_d  = addr_base_q;
      bank_sel_n_d = '1;
      bank_sel_n_d[bank_idx_q] = 1'b0;
      if (seg_end) begin
         word_cnt_d = '0;
         if (last_bank) begin
            bank_idx_d = '0;
            // Last segment of the last pass wraps back to the oldest region
            if (last_pass) begin
               pass_idx_d  = '0;
               addr_base_d = '0;
            end else begin
               pass_idx_d  = pass_idx_q + PASS_W'(1);
               addr_base_d = addr_base_q + ADDR_W'(SEG_LEN);
            end
         end else begin
            bank_idx_d = bank_idx_q + BANK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         bank_idx_q   <= '0;
         pass_idx_q   <= '0;
         addr_base_q  <= '0;
         bank_sel_n_q <= '1;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         seg_done_q   <= 1'b0;
         seg_bank_q   <= '0;
         seg_pass_q   <= '0;
         fill_done_q  <= 1'b0;
      end else begin
         bank_sel_n_q <= '1;
         seg_done_q   <= 1'b0;
         fill_done_q  <= 1'b0;
         if (start_i) begin
            state_q     <= S_FILL;
            word_cnt_q  <= '0;
            bank_idx_q  <= '0;
            pass_idx_q  <= '0;
            addr_base_q <= '0;
         end else if (accept) begin
            bank_sel_n_q <= bank_sel_n_d;
            wr_addr_q    <= addr_base_q + ADDR_W'(word_cnt_q);
            wr_data_q    <= in_data_i;
            word_cnt_q   <= word_cnt_d;
            bank_idx_q   <= bank_idx_d;
            pass_idx_q   <= pass_idx_d;
            addr_base_q  <= addr_base_d;
            if (seg_end) begin
               seg_done_q  <= 1'b1;
               seg_bank_q  <= bank_idx_q;
               seg_pass_q  <= pass_idx_q;
               fill_done_q <= last_bank && last_pass;
            end
         end
      end
   end

   assign bank_sel_n_o = bank_sel_n_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign seg_done_o   = seg_done_q;
   assign seg_bank_o   = seg_bank_q;
   assign seg_pass_o   = seg_pass_q;
   assign fill_done_o  = fill_done_q;

endmodule
`default_nettype wire

// File: doc/ref_bank_writer.md
Name: ref_bank_writer

Overview:
- Write-side sequencer for the reference-pixel SRAM banks: ME search-window storage built from NUM_BANK dual-port banks, each 64-bit (8 pixels) x 96 deep.
- Accepts a valid/ready stream of 64-bit reference words and fills the banks round-robin in segments of SEG_LEN words: bank0 gets 24 words, then bank1, and so on.
- After the last bank, the pass counter advances and the next segment lands at the next 24-word region of each bank.
- After DEPTH/SEG_LEN passes, addresses wrap to 0, overwriting the oldest data.
- Drives the banks' active-low write selects, the shared write address and the shared write data. Emits segment/fill status for the read-side controller.

Parameters:
- NUM_BANK, 4, number of banks sequenced (>=2)
- SEG_LEN, 24, words written to one bank before switching to the next
- DEPTH, 96, words per bank; must be an integer multiple of SEG_LEN; PASSES = DEPTH/SEG_LEN
- ADDR_W, 7, bank address width
- DATA_W, 64, word width (8 pixels x 8 bit)

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: pulse; (re)starts the fill at bank0/pass0/word0.
- hold, in, 1: back-pressure from the reader; while high, no words are accepted.
- in_valid, in, 1: input word valid.
- in_data, in, DATA_W: input reference word.
- in_ready, out, 1: writer can accept a word.
- bank_sel_n, out, NUM_BANK: per-bank write enable, active low (to each bank's Bank_sel).
- wr_addr, out, ADDR_W: shared write address.
- wr_data, out, DATA_W: shared write data.
- seg_done, out, 1: one-cycle pulse when the last word of a segment is written.
- seg_bank, out, clog2(NUM_BANK): bank of the completed segment; valid with seg_done.
- seg_pass, out, clog2(PASSES): pass of the completed segment; valid with seg_done.
- fill_done, out, 1: one-cycle pulse when the final segment (last bank, last pass) is written.
- busy, out, 1: high in FILL state.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; word_cnt, bank_idx, pass_idx and addr_base all 0.
  - bank_sel_n all 1; wr_addr 0; wr_data 0; seg_done, fill_done, busy 0; seg_bank, seg_pass 0.
  - rst asserted mid-fill: the in-flight write is cancelled (bank_sel_n forced all 1 immediately), and no seg_done/fill_done is issued.
- States:
  - IDLE: in_ready=0. start -> FILL.
  - FILL: in_ready = !hold && !start. start -> FILL with all counters cleared; any write registered in that same cycle still completes.
  - There is no return to IDLE except by reset; fill is continuous, with wrap.
- Handshake: a word is accepted when in_valid && in_ready. in_valid may drop freely; a gap leaves the counters unchanged.
- Write timing: all outputs are registered. An accept at cycle t gives, at cycle t+1:
  - bank_sel_n[bank_idx]=0, all other bits 1;
  - wr_addr = addr_base + word_cnt (value before increment);
  - wr_data = in_data.
  - With no accept at t, bank_sel_n is all 1 at t+1; wr_addr/wr_data hold.
- Counter update on accept:
  - word_cnt++.
  - If word_cnt==SEG_LEN-1: word_cnt=0 and seg_done=1 at t+1, with seg_bank/seg_pass equal to the pre-update bank_idx/pass_idx; then:
    - if bank_idx==NUM_BANK-1: bank_idx=0, and
      - if pass_idx==PASSES-1: pass_idx=0, addr_base=0, fill_done=1 at t+1 (wrap; the next word overwrites bank0 addr0);
      - else pass_idx++, addr_base += SEG_LEN;
    - else bank_idx++ (pass_idx and addr_base unchanged).
- Arithmetic: addr_base is held as a running register. No multiplier. Maximum address is DEPTH-1 (95), which fits ADDR_W.
- No two bank_sel_n bits are ever low in the same cycle.
- Back-to-back accepts sustain one write per cycle.

Test Plan:
- Reset then start, 24 consecutive words D0..D23 -> bank_sel_n=4'b1110 for 24 cycles, wr_addr 0..23, wr_data D0..D23 each one cycle after accept; seg_done on the last write with seg_bank=0, seg_pass=0.
- 96 words continuous -> bank0 addr0-23, bank1 addr0-23, bank2 addr0-23, bank3 addr0-23; word 96 -> bank0 addr24.
- 384 words -> word 383 written to bank3 addr95 with fill_done=1, seg_bank=3, seg_pass=3; word 384 -> bank0 addr0 (wrap), with no fill_done pulse.
- hold=1 for 5 cycles in mid-segment (after word 10) with in_valid=1 -> in_ready=0 and bank_sel_n all 1 for those cycles; word 11 then lands at bank0 addr11, with no skipped or duplicated address.
- start asserted at word 50 with in_valid=1 -> word 49 (bank2 addr1) still written; no word is accepted that cycle; the next word goes to bank0 addr0.
- rst asserted during the write of word 30 -> bank_sel_n=all 1 asynchronously, in_ready=0, busy=0; after release, no writes occur until start.
